dense_row_server: RTL

//  Responder for the dense-matrix row-request interface of the sparse-dense multiplier.

---
 rtl/dense_pkg.sv | 32 +++
 rtl/dense_tag_pipe.sv | 34 +++
 rtl/dense_row_server.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - shared constants, FSM encoding and tag layout for the dense row server
package dense_pkg;

    localparam int DATA_W   = 32;
    localparam int ROW_W    = 10;
    localparam int NUM_ROWS = 560;
    localparam int ROW_LEN  = 560;
    localparam int PAIRS    = ROW_LEN / 2;
    localparam int MEM_AW   = 18;
    localparam int PIDX_W   = $clog2(PAIRS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    typedef struct packed {
        logic             valid;
        logic             last;
        logic [ROW_W-1:0] row;
    } tag_t;

    // row * PAIRS as a sum of shifted copies of row, one per set bit of PAIRS
    function automatic logic [MEM_AW-1:0] row_base(input logic [ROW_W-1:0] row);
        logic [MEM_AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < PIDX_W; i++) begin
            if (PAIRS[i]) acc = acc + (MEM_AW'(row) << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/dense_tag_pipe.sv
// rtl/dense_tag_pipe.sv - delay line carrying beat tags alongside bank read data
module dense_tag_pipe
    import dense_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = $bits(tag_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] tag_in,
    output logic [W-1:0] tag_out,
    output logic         any_valid
);

    logic [W-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    // the valid flag is the top bit of every tag
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stages[i][W-1];
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/dense_row_server.sv
// rtl/dense_row_server.sv - streams requested dense-matrix rows as pairs from two interleaved banks
module dense_row_server
    import dense_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ROW_W-1:0]  req_row,
    output logic              req_ready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout1,
    input  logic [DATA_W-1:0] mem_dout2,
    output logic [DATA_W-1:0] datain1,
    output logic [DATA_W-1:0] datain2,
    output logic              out_valid,
    output logic              out_last,
    output logic [ROW_W-1:0]  out_row,
    output logic              busy,
    output logic              err_range
);

    logic [1:0]        state;
    logic [PIDX_W-1:0] pidx;
    logic [MEM_AW-1:0] base;
    logic [ROW_W-1:0]  cur_row;
    logic              pend_full;
    logic [ROW_W-1:0]  pend_row;
    logic [1:0]        drain_cnt;

    logic              accept;
    logic              in_range;
    logic              acc_ok;
    logic              pidx_last;
    logic              load_en;
    logic              take_pend;
    logic              to_pend;
    logic [ROW_W-1:0]  load_row;

    tag_t              tag_in;
    tag_t              tag_out;
    logic              tag_busy;

    assign req_ready = !pend_full;
    assign accept    = req_valid && req_ready;
    assign in_range  = req_row < ROW_W'(NUM_ROWS);
    assign acc_ok    = accept && in_range;
    assign pidx_last = pidx == PIDX_W'(PAIRS - 1);

    // a new row may start whenever no row is mid-stream; the pending slot has priority
    always_comb begin
        load_en   = 1'b0;
        take_pend = 1'b0;
        load_row  = req_row;
        if (state != ST_STREAM || pidx_last) begin
            if (pend_full) begin
                load_en   = 1'b1;
                take_pend = 1'b1;
                load_row  = pend_row;
            end else if (acc_ok) begin
                load_en = 1'b1;
            end
        end
    end

    assign to_pend = acc_ok && !load_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pidx      <= '0;
            base      <= '0;
            cur_row   <= '0;
            pend_full <= 1'b0;
            pend_row  <= '0;
            drain_cnt <= '0;
            err_range <= 1'b0;
        end else begin
            err_range <= accept && !in_range;

            if (take_pend) begin
                pend_full <= 1'b0;
            end else if (to_pend) begin
                pend_full <= 1'b1;
                pend_row  <= req_row;
            end

            if (load_en) begin
                state   <= ST_STREAM;
                base    <= row_base(load_row);
                cur_row <= load_row;
                pidx    <= '0;
            end else begin
                case (state)
                    ST_STREAM: begin
                        if (pidx_last) begin
                            state     <= ST_DRAIN;
                            pidx      <= '0;
                            drain_cnt <= 2'(MEM_LAT - 1);
                        end else begin
                            pidx <= pidx + PIDX_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt == 2'd0) state <= ST_IDLE;
                        else drain_cnt <= drain_cnt - 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_en   = state == ST_STREAM;
    assign mem_addr = mem_en ? base + MEM_AW'(pidx) : '0;

    always_comb begin
        tag_in.valid = mem_en;
        tag_in.last  = mem_en && pidx_last;
        tag_in.row   = mem_en ? cur_row : '0;
    end

    dense_tag_pipe #(
        .DEPTH (MEM_LAT),
        .W     ($bits(tag_t))
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (tag_busy)
    );

    assign out_valid = tag_out.valid;
    assign out_last  = tag_out.last;
    assign out_row   = tag_out.row;
    assign datain1   = tag_out.valid ? mem_dout1 : '0;
    assign datain2   = tag_out.valid ? mem_dout2 : '0;
    assign busy      = (state != ST_IDLE) || tag_busy;

endmodule
